ack_nak_scheduler: RTL and testbench

ACK_NAK_SCHEDULER -- requirements
Module: ack_nak_scheduler

---
 rtl/dll_pkg.sv | 26 ++
 rtl/ack_nak_scheduler.sv | 141 ++++++++++++++
 tb/tb_ack_nak_scheduler.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dll_pkg.sv
// Shared data-link-layer types: ACK/NAK scheduler states, DLLP type, sequence width.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package dll_pkg;

  localparam int SEQ_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK_PEND,
    ST_ACK_REQ,
    ST_NAK_REQ,
    ST_NAK_BLOCK
  } ack_nak_state_e;

  typedef enum logic {
    DLLP_ACK = 1'b0,
    DLLP_NAK = 1'b1
  } dllp_type_e;

  // Saturating increment for the 4-bit coalescing counter.
  function automatic logic [3:0] cnt_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

endpackage

// File: rtl/ack_nak_scheduler.sv
// ACK/NAK scheduler: coalesces good TLPs into ACKs, schedules NAKs, requests DLLP transmit.
// Latency: request registered one cycle after the triggering pulse; drops the cycle after req&&gnt.
// Backpressure: dllp_req/type/seq held stable until dllp_gnt; events during the wait are recorded.
// Ports: clk/rst (sync, active-high); tlp_good/tlp_dup/tlp_bad pulses + next_rcv_seq from
//   the sequence checker; lat_timeout/lat_timer_start to the peer latency timer;
//   dllp_req/dllp_gnt/dllp_is_nak/dllp_seq to the TX DLLP arbiter; ack/nak_scheduled status.
module ack_nak_scheduler
  import dll_pkg::*;
#(
  parameter int ACK_COALESCE = 4,
  parameter int SEQ_W        = dll_pkg::SEQ_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tlp_good,
  input  logic             tlp_dup,
  input  logic             tlp_bad,
  input  logic [SEQ_W-1:0] next_rcv_seq,
  input  logic             lat_timeout,
  input  logic             dllp_gnt,
  output logic             lat_timer_start,
  output logic             ack_scheduled,
  output logic             nak_scheduled,
  output logic             dllp_req,
  output logic             dllp_is_nak,
  output logic [SEQ_W-1:0] dllp_seq
);

  localparam logic [3:0] COAL = 4'(ACK_COALESCE);

  ack_nak_state_e   state;
  dllp_type_e       dllp_type;
  logic [3:0]       cnt;
  logic             nak_pend;   // bad TLP seen while an ACK waits for grant
  logic             good_rec;   // good TLP seen while a request waits for grant

  logic             ev_bad, ev_dup, ev_good, grant;
  logic [SEQ_W-1:0] seq_m1;

  // Priority bad > dup > good.
  assign ev_bad  = tlp_bad;
  assign ev_dup  = tlp_dup & ~tlp_bad;
  assign ev_good = tlp_good & ~tlp_dup & ~tlp_bad;
  assign grant   = dllp_req & dllp_gnt;
  // AckNak_Seq_Num is the last good sequence number; wraps 0 -> all ones.
  assign seq_m1  = next_rcv_seq - SEQ_W'(1);

  assign dllp_is_nak = dllp_type;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= 4'd0;
      nak_pend        <= 1'b0;
      good_rec        <= 1'b0;
      lat_timer_start <= 1'b0;
      ack_scheduled   <= 1'b0;
      nak_scheduled   <= 1'b0;
      dllp_req        <= 1'b0;
      dllp_type       <= DLLP_ACK;
      dllp_seq        <= '0;
    end else begin
      lat_timer_start <= 1'b0;
      unique case (state)
        ST_IDLE, ST_NAK_BLOCK: begin
          // NAK_BLOCK ignores bad/dup/timeout so only one NAK goes out per error episode.
          if (ev_bad && state == ST_IDLE) begin
            state <= ST_NAK_REQ; cnt <= 4'd0; dllp_req <= 1'b1; dllp_type <= DLLP_NAK;
            dllp_seq <= seq_m1; ack_scheduled <= 1'b0; nak_scheduled <= 1'b1;
          end else if ((ev_dup && state == ST_IDLE) || (ev_good && COAL == 4'd1)) begin
            state <= ST_ACK_REQ; cnt <= 4'd0; dllp_req <= 1'b1; dllp_type <= DLLP_ACK;
            dllp_seq <= seq_m1; ack_scheduled <= 1'b1; nak_scheduled <= 1'b0;
          end else if (ev_good) begin
            state <= ST_ACK_PEND; cnt <= 4'd1; lat_timer_start <= 1'b1;
            ack_scheduled <= 1'b1; nak_scheduled <= 1'b0;
          end
        end

        ST_ACK_PEND: begin
          if (ev_bad) begin
            // Pending ACK is discarded; the NAK carries the same acknowledgement.
            state <= ST_NAK_REQ; cnt <= 4'd0; dllp_req <= 1'b1; dllp_type <= DLLP_NAK;
            dllp_seq <= seq_m1; ack_scheduled <= 1'b0; nak_scheduled <= 1'b1;
          end else if (ev_dup || lat_timeout || (ev_good && cnt_inc(cnt) >= COAL)) begin
            state <= ST_ACK_REQ; cnt <= 4'd0; dllp_req <= 1'b1; dllp_type <= DLLP_ACK;
            dllp_seq <= seq_m1;
          end else if (ev_good) begin
            cnt <= cnt_inc(cnt);
          end
        end

        ST_ACK_REQ: begin
          if (ev_bad) begin
            nak_pend      <= 1'b1;
            nak_scheduled <= 1'b1;
          end
          if (ev_good) begin
            good_rec <= 1'b1;
            cnt      <= good_rec ? cnt_inc(cnt) : 4'd1;
          end
          if (grant) begin
            good_rec <= 1'b0;
            nak_pend <= 1'b0;
            if (nak_pend || ev_bad) begin
              // dllp_req stays high: back-to-back request, new type and sequence.
              state <= ST_NAK_REQ; cnt <= 4'd0; dllp_type <= DLLP_NAK;
              dllp_seq <= seq_m1; ack_scheduled <= 1'b0; nak_scheduled <= 1'b1;
            end else if (good_rec || ev_good) begin
              state <= ST_ACK_PEND; dllp_req <= 1'b0; lat_timer_start <= 1'b1;
            end else begin
              state <= ST_IDLE; cnt <= 4'd0; dllp_req <= 1'b0; ack_scheduled <= 1'b0;
            end
          end
        end

        ST_NAK_REQ: begin
          if (ev_good) begin
            good_rec <= 1'b1;
            cnt      <= good_rec ? cnt_inc(cnt) : 4'd1;
          end
          if (grant) begin
            dllp_req <= 1'b0;
            good_rec <= 1'b0;
            if (good_rec || ev_good) begin
              state <= ST_ACK_PEND; lat_timer_start <= 1'b1;
              ack_scheduled <= 1'b1; nak_scheduled <= 1'b0;
            end else begin
              state <= ST_NAK_BLOCK; cnt <= 4'd0;
            end
          end
        end

        default: begin
          state <= ST_IDLE; cnt <= 4'd0; nak_pend <= 1'b0; good_rec <= 1'b0;
          dllp_req <= 1'b0; ack_scheduled <= 1'b0; nak_scheduled <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ack_nak_scheduler.sv
// Directed bench for ack_nak_scheduler; expected DLLPs queued at stimulus, checked at handshake.
// Latency: n/a.
// Backpressure: bench drives dllp_gnt explicitly, including long stalls.
module tb_ack_nak_scheduler;

  typedef struct packed {
    logic        is_nak;
    logic [11:0] seq;
  } dllp_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        tlp_good, tlp_dup, tlp_bad, lat_timeout, dllp_gnt;
  logic [11:0] next_rcv_seq;
  logic        lat_timer_start, ack_scheduled, nak_scheduled, dllp_req, dllp_is_nak;
  logic [11:0] dllp_seq;

  dllp_exp_t sb[$];
  dllp_exp_t mon_exp;
  int        n_checks = 0;
  int        n_fail   = 0;
  int        n_starts = 0;
  int        starts0;

  ack_nak_scheduler #(.ACK_COALESCE(4), .SEQ_W(12)) dut (
    .clk(clk), .rst(rst),
    .tlp_good(tlp_good), .tlp_dup(tlp_dup), .tlp_bad(tlp_bad),
    .next_rcv_seq(next_rcv_seq), .lat_timeout(lat_timeout), .dllp_gnt(dllp_gnt),
    .lat_timer_start(lat_timer_start), .ack_scheduled(ack_scheduled),
    .nak_scheduled(nak_scheduled), .dllp_req(dllp_req),
    .dllp_is_nak(dllp_is_nak), .dllp_seq(dllp_seq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_good(input logic [11:0] s);
    tlp_good = 1'b1; next_rcv_seq = s; tick(); tlp_good = 1'b0;
  endtask

  task automatic pulse_dup(input logic [11:0] s);
    tlp_dup = 1'b1; next_rcv_seq = s; tick(); tlp_dup = 1'b0;
  endtask

  task automatic pulse_bad(input logic [11:0] s);
    tlp_bad = 1'b1; next_rcv_seq = s; tick(); tlp_bad = 1'b0;
  endtask

  task automatic pulse_timeout();
    lat_timeout = 1'b1; tick(); lat_timeout = 1'b0;
  endtask

  // Waits (bounded) for a request, then grants it for exactly one cycle.
  task automatic do_grant(input string tag);
    int n = 0;
    while (dllp_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req_seen"}, dllp_req, 1);
    dllp_gnt = 1'b1; tick(); dllp_gnt = 1'b0;
  endtask

  // Scoreboard: every completed handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && dllp_req === 1'b1 && dllp_gnt === 1'b1) begin
      check("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check("sb_type", dllp_is_nak, mon_exp.is_nak);
        check("sb_seq", dllp_seq, mon_exp.seq);
      end
    end
    if (lat_timer_start === 1'b1) n_starts++;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tlp_good = 1'b0; tlp_dup = 1'b0; tlp_bad = 1'b0;
    lat_timeout = 1'b0; dllp_gnt = 1'b0; next_rcv_seq = '0;
    tick(); tick();
    check("rst_outputs", {lat_timer_start, ack_scheduled, nak_scheduled,
                          dllp_req, dllp_is_nak, dllp_seq}, 0);
    rst = 1'b0;
    tick();
    check("idle_quiet", {ack_scheduled, nak_scheduled, dllp_req}, 0);

    // Four goods coalesce into one ACK for seq 3.
    starts0 = n_starts;
    pulse_good(12'd1);
    check("coal_pend", {ack_scheduled, dllp_req}, 2'b10);
    pulse_good(12'd2);
    pulse_good(12'd3);
    check("coal_no_req_yet", dllp_req, 0);
    sb.push_back('{is_nak: 1'b0, seq: 12'd3});
    pulse_good(12'd4);
    check("coal_req", {dllp_req, dllp_is_nak, dllp_seq}, {1'b1, 1'b0, 12'd3});
    do_grant("coal");
    check("coal_idle", {dllp_req, ack_scheduled}, 0);
    check("coal_one_start", n_starts - starts0, 1);

    // Sequence wrap: next_rcv_seq 0 acknowledges 4095.
    pulse_good(12'd0);
    sb.push_back('{is_nak: 1'b0, seq: 12'hFFF});
    pulse_timeout();
    check("wrap_seq", {dllp_req, dllp_seq}, {1'b1, 12'hFFF});
    do_grant("wrap");

    // NAK then blocking of further errors.
    sb.push_back('{is_nak: 1'b1, seq: 12'd6});
    pulse_bad(12'd7);
    check("nak_req", {dllp_req, dllp_is_nak, nak_scheduled}, 3'b111);
    do_grant("nak");
    check("nak_block", {dllp_req, nak_scheduled}, 2'b01);
    pulse_bad(12'd7);
    pulse_dup(12'd7);
    pulse_timeout();
    tick();
    check("nak_block_quiet", {dllp_req, nak_scheduled}, 2'b01);
    starts0 = n_starts;
    pulse_good(12'd8);
    check("nak_exit", {nak_scheduled, ack_scheduled, lat_timer_start}, 3'b011);
    sb.push_back('{is_nak: 1'b0, seq: 12'd7});
    pulse_timeout();
    do_grant("nak_cleanup");

    // Long grant stall with good and bad arriving; NAK follows the ACK.
    sb.push_back('{is_nak: 1'b0, seq: 12'd19});
    pulse_dup(12'd20);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin tlp_good = 1'b1; next_rcv_seq = 12'd21; end
      if (i == 5) tlp_bad = 1'b1;
      tick();
      tlp_good = 1'b0; tlp_bad = 1'b0;
      check("stall_stable", {dllp_req, dllp_is_nak, dllp_seq}, {1'b1, 1'b0, 12'd19});
    end
    check("stall_nak_sched", nak_scheduled, 1);
    sb.push_back('{is_nak: 1'b1, seq: 12'd20});
    do_grant("stall_ack");
    check("stall_nak_next", {dllp_req, dllp_is_nak, dllp_seq}, {1'b1, 1'b1, 12'd20});
    do_grant("stall_nak");
    check("stall_block", {dllp_req, ack_scheduled, nak_scheduled}, 3'b001);
    pulse_good(12'd22);
    sb.push_back('{is_nak: 1'b0, seq: 12'd21});
    pulse_timeout();
    do_grant("stall_cleanup");

    // Good recorded during ACK_REQ restarts coalescing at 1 after the grant.
    sb.push_back('{is_nak: 1'b0, seq: 12'd39});
    pulse_dup(12'd40);
    pulse_good(12'd41);
    do_grant("rec");
    check("rec_pend", {dllp_req, ack_scheduled, lat_timer_start}, 3'b011);
    pulse_good(12'd42);
    pulse_good(12'd43);
    check("rec_cnt3_no_req", dllp_req, 0);
    sb.push_back('{is_nak: 1'b0, seq: 12'd43});
    pulse_good(12'd44);
    check("rec_cnt4_req", {dllp_req, dllp_seq}, {1'b1, 12'd43});
    do_grant("rec2");

    // Simultaneous good+bad from IDLE: NAK wins, no timer start.
    starts0 = n_starts;
    tlp_good = 1'b1; tlp_bad = 1'b1; next_rcv_seq = 12'd30;
    tick();
    tlp_good = 1'b0; tlp_bad = 1'b0;
    check("prio_nak", {dllp_req, dllp_is_nak, dllp_seq, lat_timer_start}, {1'b1, 1'b1, 12'd29, 1'b0});
    tick();
    check("prio_no_start", n_starts - starts0, 0);

    // Reset during NAK_REQ drops the request without a grant.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_in_nak", {lat_timer_start, ack_scheduled, nak_scheduled,
                         dllp_req, dllp_is_nak, dllp_seq}, 0);
    pulse_good(12'd1);
    check("rst_to_idle", {ack_scheduled, lat_timer_start, dllp_req}, 3'b110);
    tick();
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
